// File: rtl/cby_0__1__cfg_loader.sv
// Memory-bank config loader for tile (0,1): one byte per group, setup -> wl pulse -> hold.
// Byte accepted at T reaches IDLE again at T+3+WL_PULSE; cfg_ready is low while a group write is in flight.
module cby_0__1__cfg_loader #(
  parameter int WL_PULSE = 2
) (
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_valid,
  input  logic        cfg_last,
  output logic        cfg_ready,
  output logic [7:0]  bl,
  output logic [7:0]  wl,
  output logic [71:0] bl_0,
  output logic [71:0] wl_0,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int NUM_GROUPS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  gidx;
  logic [3:0]  pulse_cnt;
  logic [7:0]  data_q;
  logic        last_q;
  logic        accept;
  logic [79:0] bl_all;
  logic [79:0] wl_all;

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= IDLE;
      gidx      <= 4'd0;
      pulse_cnt <= 4'd0;
      data_q    <= 8'd0;
      last_q    <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == IDLE);
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= cfg_data;
            last_q <= cfg_last;
          end
        end
        SETUP: pulse_cnt <= 4'(WL_PULSE - 1);
        PULSE: begin
          if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
        end
        HOLD: begin
          // Frame outcome is resolved here so the pulse lands in the first IDLE cycle.
          if (gidx == 4'(NUM_GROUPS - 1)) begin
            gidx     <= 4'd0;
            cfg_done <= last_q;
            cfg_err  <= !last_q;
          end else if (last_q) begin
            gidx    <= 4'd0;
            cfg_err <= 1'b1;
          end else begin
            gidx <= gidx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = PULSE;
      PULSE:   if (pulse_cnt == 4'd0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bl is driven from SETUP through HOLD so it brackets the wl pulse by one cycle each side.
  always_comb begin
    bl_all = 80'd0;
    wl_all = 80'd0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (gidx == 4'(g)) begin
        bl_all[8*g +: 8] = (state != IDLE)  ? data_q : 8'h00;
        wl_all[8*g +: 8] = (state == PULSE) ? 8'hFF  : 8'h00;
      end
    end
  end

  assign bl   = bl_all[7:0];
  assign wl   = wl_all[7:0];
  assign bl_0 = bl_all[79:8];
  assign wl_0 = wl_all[79:8];

endmodule

// File: doc/cby_0__1__cfg_loader.md
# cby_0__1__cfg_loader

Memory-bank configuration loader for the left-edge I/O tile at column 0, row 1. The tile contains grid_io_left_0__1_ and cby_0__1_. The loader sits directly upstream of the tile's `bl`/`wl` (8 bits each) and `bl_0`/`wl_0` (72 bits each) configuration ports. It accepts a byte-wide configuration stream over a valid/ready handshake and writes the tile's 80 configuration bits one 8-bit group at a time. Each group write follows a setup → word-line pulse → hold sequence.

## Interface
Parameters:
- `WL_PULSE`, default 2: number of cycles the word lines stay high per group. Legal range 1..15.

Ports:
- `prog_clk`, input, 1: configuration clock. All logic is on the rising edge.
- `prog_reset`, input, 1: synchronous, active-high reset.
- `cfg_data`, input, 8: configuration byte. Bit 0 maps to the lowest bl index of the group.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_last`, input, 1: marks the final byte of a tile frame. Qualified by `cfg_valid`.
- `cfg_ready`, output, 1: the loader can accept a byte.
- `bl`, output, 8: grid_io bit lines (group 0).
- `wl`, output, 8: grid_io word lines (group 0).
- `bl_0`, output, 72: cby bit lines (groups 1..9).
- `wl_0`, output, 72: cby word lines (groups 1..9).
- `cfg_done`, output, 1: one-cycle pulse when a frame completes correctly.
- `cfg_err`, output, 1: one-cycle pulse when frame framing is wrong.

## Operation
- A frame is 10 bytes. The group index `gidx` (4 bits, 0..9) selects where each byte goes:
  - byte 0 → `bl[7:0]` / `wl[7:0]`
  - byte k (k = 1..9) → `bl_0[8(k-1)+7 : 8(k-1)]` / `wl_0` over the same range
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - `cfg_ready`=1. All bl and wl outputs are 0.
  - On `cfg_valid && cfg_ready`: capture `cfg_data` and `cfg_last`, then go to SETUP.
- SETUP (1 cycle):
  - Selected group's bl = captured byte. Every other bl bit = 0.
  - All wl = 0. `cfg_ready`=0. Go to PULSE and load the pulse counter with `WL_PULSE-1`.
- PULSE (`WL_PULSE` cycles):
  - bl unchanged from SETUP.
  - Selected group's wl = 8'hFF. Every other wl bit = 0.
  - Counter decrements each cycle. Leave for HOLD when the counter reads 0.
- HOLD (1 cycle):
  - bl held, all wl = 0.
  - Compute the frame outcome, then return to IDLE:
    - `gidx`=9 with captured `cfg_last`=1: `cfg_done` pulses in the next IDLE cycle; `gidx` goes to 0.
    - `gidx`=9 with captured `cfg_last`=0: `cfg_err` pulses; `gidx` goes to 0.
    - `gidx`<9 with captured `cfg_last`=1: `cfg_err` pulses; `gidx` goes to 0.
    - Otherwise: `gidx` increments.
- A byte that triggers `cfg_err` has still been written to the tile. No rollback.
- wl high and bl changing never happen in the same cycle. bl is stable for one cycle before wl rises and for one cycle after wl falls.
- Exactly one group's wl is ever high at a time.

## Timing
- Reset values: state=IDLE, `gidx`=0, pulse counter=0, `cfg_ready`=1, all bl and wl = 0, `cfg_done`=0, `cfg_err`=0.
- Accept edge at cycle T:
  - SETUP at T+1
  - PULSE from T+2 to T+1+`WL_PULSE`
  - HOLD at T+2+`WL_PULSE`
  - IDLE (`cfg_ready`=1) at T+3+`WL_PULSE`
- Throughput: one byte per `WL_PULSE`+3 cycles. Full frame minimum: 10·(`WL_PULSE`+3) cycles.
- `cfg_done` and `cfg_err` are high only in the first IDLE cycle after the final HOLD. The loader can accept a new byte in that same cycle.
- `cfg_ready` is registered and does not depend combinationally on `cfg_valid`.
- `cfg_data` and `cfg_last` are ignored unless a valid/ready transfer occurs.
- Reset asserted in any state, including mid-PULSE:
  - On the next edge, wl drops to 0 and bl drops to 0. No further pulse is issued.
  - `gidx` goes to 0 and any partial frame is discarded.
  - No `cfg_done` or `cfg_err` pulse is produced.
- Reset wins over a simultaneous `cfg_valid`.

## Test plan
- **Reset:** hold `prog_reset` for 3 cycles with `cfg_valid`=1.
  - Expect `cfg_ready`=1, all bl/wl=0, no done/err.
  - After release, the first accepted byte lands in group 0.
- **Full frame, `WL_PULSE`=2:** send bytes 8'hA5, then 8'h01..8'h09, with `cfg_last` on byte 9 and `cfg_valid` held high.
  - `bl`=8'hA5 while `wl`=8'hFF for exactly 2 cycles.
  - `bl_0[71:64]`=8'h09 while `wl_0[71:64]`=8'hFF.
  - Bytes are accepted 5 cycles apart.
  - `cfg_done` pulses once, 5 cycles after the last accept.
- **Backpressure gaps:** deassert `cfg_valid` for random 0–7 cycle gaps.
  - Output sequence identical to the full-frame scenario.
  - `cfg_data` toggled while `cfg_valid`=0 must have no effect on bl.
- **Early `cfg_last`:** assert `cfg_last` on byte 3.
  - `cfg_err` pulses and byte 3 is written to `bl_0[23:16]`.
  - The next byte goes to group 0 (`bl`).
- **Missing `cfg_last` on byte 9:** `cfg_err` pulses, no `cfg_done`, and `gidx` returns to 0.
- **Mid-pulse reset, `WL_PULSE`=4:** assert reset in the second PULSE cycle of group 5.
  - Next cycle: `wl_0`=0 and `bl_0`=0.
  - A new frame then writes correctly starting from group 0.
